mul_hilo_ctrl: RTL and testbench

Sequential control stage that sits directly upstream and downstream of the combinational signed Booth multiplier `mul_32_bit`. It accepts a multiply request and registers the operands that drive the multiplier. It holds them stable for a fixed settle window, then captures the 64-bit product into the architectural HI/LO registers. It also serves HI/LO reads and direct HI/LO writes for the datapath (mfhi/mflo/mthi/mtlo).

---
 rtl/mul_hilo_ctrl.sv | 122 ++++++++++++
 tb/tb_mul_hilo_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_hilo_ctrl.sv
// mul_hilo_ctrl: control stage wrapped around the combinational signed multiplier.
// It registers the multiplier operands, waits a fixed settle window, then captures
// the 64-bit product into HI/LO. It also serves direct HI/LO writes (mthi/mtlo).
// Optional feature macro: MUL_ZERO_SHORTCUT_EN. When it is defined, a request with a
// zero operand completes on the accept edge without entering WAIT.
module mul_hilo_ctrl #(
    // Cycles the multiplier output may settle before capture; legal range 1..15.
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        i_clock,
    input  logic        i_clear,
    input  logic        i_start,
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    output logic [31:0] o_mul_a,
    output logic [31:0] o_mul_b,
    input  logic [63:0] i_mul_z,
    input  logic        i_hi_wr,
    input  logic [31:0] i_hi_in,
    input  logic        i_lo_wr,
    input  logic [31:0] i_lo_in,
    output logic [31:0] o_hi_out,
    output logic [31:0] o_lo_out,
    output logic        o_busy,
    output logic        o_done
);

    // The counter is loaded with SETTLE_CYCLES-1 so that the capture edge falls
    // exactly SETTLE_CYCLES edges after the accept edge.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

`ifdef MUL_ZERO_SHORTCUT_EN
    // A zero operand makes the product zero, so no settle window is needed.
    logic w_zero_op;
    assign w_zero_op = (i_op_a == 32'd0) || (i_op_b == 32'd0);
`endif

    // Controller FSM, settle counter, operand registers and HI/LO.
    // Direct writes are applied first so a capture later in the block overrides them.
    always_ff @(posedge i_clock or negedge i_clear) begin
        if (!i_clear) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_mul_a <= 32'd0;
            r_mul_b <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (i_hi_wr) begin
                r_hi <= i_hi_in;
            end
            if (i_lo_wr) begin
                r_lo <= i_lo_in;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        // Operands stay in these registers after capture; they are
                        // only replaced by the next accepted request.
                        r_mul_a <= i_op_a;
                        r_mul_b <= i_op_b;
`ifdef MUL_ZERO_SHORTCUT_EN
                        if (w_zero_op) begin
                            r_hi   <= 32'd0;
                            r_lo   <= 32'd0;
                            r_done <= 1'b1;
                        end else begin
                            r_cnt   <= CNT_LOAD;
                            r_state <= ST_WAIT;
                        end
`else
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_WAIT;
`endif
                    end
                end

                ST_WAIT: begin
                    // Start is not looked at here: requests while busy are dropped.
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_hi    <= i_mul_z[63:32];
                        r_lo    <= i_mul_z[31:0];
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Busy is decoded straight from the state so it tracks WAIT exactly.
    assign o_busy   = (r_state == ST_WAIT);
    assign o_done   = r_done;
    assign o_mul_a  = r_mul_a;
    assign o_mul_b  = r_mul_b;
    assign o_hi_out = r_hi;
    assign o_lo_out = r_lo;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Testbench for mul_hilo_ctrl. The multiplier is modelled behaviourally from the DUT's
// operand outputs. Expected products are queued when a request is accepted, and a
// negedge monitor pops and compares them whenever done is seen.
module tb_mul_hilo_ctrl;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        i_clear;
    logic        i_start;
    logic [31:0] i_op_a;
    logic [31:0] i_op_b;
    logic [31:0] o_mul_a;
    logic [31:0] o_mul_b;
    logic [63:0] mul_z;
    logic        i_hi_wr;
    logic [31:0] i_hi_in;
    logic        i_lo_wr;
    logic [31:0] i_lo_in;
    logic [31:0] o_hi_out;
    logic [31:0] o_lo_out;
    logic        o_busy;
    logic        o_done;

    always #5 clk = ~clk;

    // Stand-in for the combinational signed multiplier.
    assign mul_z = 64'(longint'($signed(o_mul_a)) * longint'($signed(o_mul_b)));

    mul_hilo_ctrl #(.SETTLE_CYCLES(S)) dut (
        .i_clock (clk),
        .i_clear (i_clear),
        .i_start (i_start),
        .i_op_a  (i_op_a),
        .i_op_b  (i_op_b),
        .o_mul_a (o_mul_a),
        .o_mul_b (o_mul_b),
        .i_mul_z (mul_z),
        .i_hi_wr (i_hi_wr),
        .i_hi_in (i_hi_in),
        .i_lo_wr (i_lo_wr),
        .i_lo_in (i_lo_in),
        .o_hi_out(o_hi_out),
        .o_lo_out(o_lo_out),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    typedef struct {
        int          cap;
        logic [63:0] prod;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;

    // Reference model state: edge index, next edge a request can be taken,
    // pending product, and architectural HI/LO and operand values.
    int          edge_cnt = 0;
    int          next_free = 0;
    bit          in_flight = 1'b0;
    int          cap_edge = 0;
    logic [63:0] pend = 64'd0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_a = 32'd0;
    logic [31:0] m_b = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Drive one cycle of inputs, apply the rules to the model at the edge,
    // then return just after the following falling edge.
    task automatic step(input bit st, input logic [31:0] a, input logic [31:0] b,
                        input bit hw, input logic [31:0] hin,
                        input bit lw, input logic [31:0] lin);
        logic [63:0] prod;
        int lat;
        i_start = st;
        i_op_a  = a;
        i_op_b  = b;
        i_hi_wr = hw;
        i_hi_in = hin;
        i_lo_wr = lw;
        i_lo_in = lin;
        @(posedge clk);
        edge_cnt++;
        if (in_flight && edge_cnt == cap_edge) begin
            m_hi = pend[63:32];
            m_lo = pend[31:0];
            in_flight = 1'b0;
        end else begin
            if (hw) m_hi = hin;
            if (lw) m_lo = lin;
        end
        if (st && edge_cnt >= next_free) begin
            prod = longint'($signed(a)) * longint'($signed(b));
            lat = S;
`ifdef MUL_ZERO_SHORTCUT_EN
            if (a == 32'd0 || b == 32'd0) lat = 0;
`endif
            m_a = a;
            m_b = b;
            sb.push_back('{edge_cnt + lat, prod});
            next_free = edge_cnt + lat + 1;
            if (lat == 0) begin
                m_hi = 32'd0;
                m_lo = 32'd0;
            end else begin
                in_flight = 1'b1;
                cap_edge = edge_cnt + lat;
                pend = prod;
            end
        end
        @(negedge clk);
        #2;
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    // One request followed by S quiet cycles; returns inside the done cycle.
    task automatic mul(input logic [31:0] a, input logic [31:0] b);
        step(1'b1, a, b, 1'b0, 32'd0, 1'b0, 32'd0);
        repeat (S) idle();
    endtask

    // Pulse clear for one cycle starting between edges.
    task automatic do_clear();
        i_clear = 1'b0;
        i_start = 1'b0;
        i_hi_wr = 1'b0;
        i_lo_wr = 1'b0;
        #1;
        chk("clr_hi", o_hi_out, 32'd0);
        chk("clr_lo", o_lo_out, 32'd0);
        chk("clr_mul_a", o_mul_a, 32'd0);
        chk("clr_mul_b", o_mul_b, 32'd0);
        chk("clr_busy", o_busy, 1'b0);
        chk("clr_done", o_done, 1'b0);
        sb.delete();
        in_flight = 1'b0;
        next_free = 0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        m_a = 32'd0;
        m_b = 32'd0;
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        #2;
        i_clear = 1'b1;
    endtask

    // Monitor: pop the scoreboard on done, and track the continuous outputs.
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_done) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", o_done, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_edge", edge_cnt, mon_e.cap);
                    chk("prod_hi", o_hi_out, mon_e.prod[63:32]);
                    chk("prod_lo", o_lo_out, mon_e.prod[31:0]);
                end
            end else if (sb.size() != 0 && sb[0].cap <= edge_cnt) begin
                chk("done_missing", o_done, 1'b1);
                void'(sb.pop_front());
            end
            chk("busy", o_busy, in_flight);
            chk("hi", o_hi_out, m_hi);
            chk("lo", o_lo_out, m_lo);
            chk("mul_a", o_mul_a, m_a);
            chk("mul_b", o_mul_b, m_b);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        i_clear = 1'b0;
        i_start = 1'b0;
        i_op_a  = 32'd0;
        i_op_b  = 32'd0;
        i_hi_wr = 1'b0;
        i_hi_in = 32'd0;
        i_lo_wr = 1'b0;
        i_lo_in = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_hi", o_hi_out, 32'd0);
        chk("rst_lo", o_lo_out, 32'd0);
        chk("rst_mul_a", o_mul_a, 32'd0);
        chk("rst_mul_b", o_mul_b, 32'd0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        #2;
        i_clear = 1'b1;
        mon_en = 1'b1;

        // 3 * -5
        mul(32'd3, 32'hFFFF_FFFB);
        chk("tp1_hi", o_hi_out, 32'hFFFF_FFFF);
        chk("tp1_lo", o_lo_out, 32'hFFFF_FFF1);

        // Largest positive squared, then most negative squared back-to-back.
        mul(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        chk("tp2_hi", o_hi_out, 32'h3FFF_FFFF);
        chk("tp2_lo", o_lo_out, 32'h0000_0001);
        mul(32'h8000_0000, 32'h8000_0000);
        chk("tp2b_hi", o_hi_out, 32'h4000_0000);
        chk("tp2b_lo", o_lo_out, 32'h0000_0000);

        // Starts during WAIT are dropped.
        step(1'b1, 32'd11, 32'd13, 1'b0, 32'd0, 1'b0, 32'd0);
        repeat (S) step(1'b1, $urandom, $urandom, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("tp3_lo", o_lo_out, 32'd143);
        idle();

        // HI write on the capture edge loses to the capture.
        step(1'b1, 32'd6, 32'd7, 1'b0, 32'd0, 1'b0, 32'd0);
        repeat (S - 1) idle();
        step(1'b0, 32'd0, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0);
        chk("tp4_hi", o_hi_out, 32'd0);
        chk("tp4_lo", o_lo_out, 32'h2A);
        step(1'b0, 32'd0, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0);
        chk("tp4_wr_hi", o_hi_out, 32'hDEAD_BEEF);

        // Clear in the middle of WAIT, then a fresh multiply.
        step(1'b1, 32'd9, 32'd9, 1'b0, 32'd0, 1'b0, 32'd0);
        do_clear();
        mul(32'd2, 32'd2);
        chk("tp5_lo", o_lo_out, 32'd4);

        // Zero operand.
        mul(32'd0, 32'h1234);
        chk("tp6_hi", o_hi_out, 32'd0);
        chk("tp6_lo", o_lo_out, 32'd0);

        // Random traffic, including starts with direct writes and zero operands.
        for (int i = 0; i < 300; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            step($urandom_range(0, 1) == 1, ra, rb,
                 $urandom_range(0, 5) == 0, $urandom,
                 $urandom_range(0, 5) == 0, $urandom);
        end

        repeat (S + 2) idle();
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
